qed_dup_issue: RTL and testbench
================================

QED_DUP_ISSUE -- requirements
Module: qed_dup_issue

Interface
REQ-001 Parameter DEPTH, 8, capacity of original-instruction FIFO (power of 2, >=2).
REQ-002 Parameter CNT_W, 8, width of num_orig/num_dup counters.
REQ-003 Parameter NOP_INST, 32'h0000007F, encoding of the QED NOP (opcode 7'b1111111).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ifu_inst  in  32  constrained instruction from fetch (ADD/SUB/logic/shift/SLT/MUL* R-type, ALU I-type, NOP; registers x0-x15).
REQ-007 ifu_valid  in  1  ifu_inst valid this cycle.
REQ-008 ifu_ready  out  1  block accepts ifu_inst this cycle.
REQ-009 exec_dup  in  1  symbolic request to enter duplicate mode.
REQ-010 stall  in  1  core not accepting issue this cycle.
REQ-011 qed_inst  out  32  instruction issued to core, registered.
REQ-012 qed_valid  out  1  qed_inst valid, registered.
REQ-013 num_orig  out  CNT_W  count of originals issued and buffered.
REQ-014 num_dup  out  CNT_W  count of duplicates issued.
REQ-015 qed_ready  out  1  consistency-check point reached.

Function
REQ-016 States ORIG, DUP, DONE; ORIG after reset; no path back to ORIG except reset.
REQ-017 ifu_ready SHALL equal (state==ORIG) && !exec_dup && !stall && !fifo_full, combinational.
REQ-018 Accept = ifu_valid && ifu_ready; next edge qed_inst<=ifu_inst, qed_valid<=1 (latency 1).
REQ-019 Accepted I-type (opcode 0010011) or R-type (opcode 0110011) SHALL push into FIFO and increment num_orig; NOP and any other opcode issued but not pushed or counted.
REQ-020 ORIG cycle with no accept and !stall: qed_valid<=0, qed_inst<=NOP_INST.
REQ-021 stall=1: qed_inst, qed_valid, FIFO, counters, state all hold.
REQ-022 ORIG->DUP when exec_dup=1 and stall=0; exec_dup wins over a simultaneous ifu_valid (instruction not accepted); exec_dup ignored outside ORIG.
REQ-023 DUP, !stall, FIFO non-empty: pop head in FIFO order, issue remapped copy with qed_valid<=1, increment num_dup.
REQ-024 Remap: rd|=5'b10000, rs1|=5'b10000; R-type also rs2|=5'b10000; opcode, funct3, funct7, immediate, shamt unchanged.
REQ-025 DUP, FIFO empty (including entry with empty FIFO): move to DONE same edge; issue NOP_INST with qed_valid<=0.
REQ-026 DONE: qed_inst=NOP_INST, qed_valid=0 every cycle.
REQ-027 qed_ready = (state==DONE) && (num_orig==num_dup) && (num_orig!=0), combinational from registers.
REQ-028 FIFO full in ORIG: ifu_ready=0, no overwrite; pointers wrap modulo DEPTH; occupancy counter distinguishes full/empty.
REQ-029 Counters saturate at 2^CNT_W-1, never wrap.

Reset
REQ-030 rst_n low SHALL immediately force state=ORIG, FIFO empty, num_orig=0, num_dup=0, qed_valid=0, qed_inst=NOP_INST, qed_ready=0.
REQ-031 Reset mid-DUP discards all buffered originals; no partial duplicate issued after release.
REQ-032 First accept possible in the first clk edge with rst_n high.

Verification
REQ-033 ADDI x1,x2,5 (32'h00510093) accepted, then exec_dup=1 -> ORIG issue 32'h00510093; DUP issue 32'h00590893; DONE with num_orig=num_dup=1, qed_ready=1.
REQ-034 ADD x3,x1,x2 (32'h002081B3) -> duplicate 32'h012889B3; order preserved across mixed ADDI/ADD sequence of 5.
REQ-035 DEPTH+1 originals offered back-to-back -> ifu_ready=0 on 9th (DEPTH=8), num_orig=8, 8 duplicates issued in order.
REQ-036 NOP_INST and exec_dup=1 same cycle -> NOP not accepted, state DUP->DONE, num_orig=0, qed_ready stays 0.
REQ-037 stall=1 for 3 cycles in DUP with 2 buffered -> outputs frozen, num_dup unchanged; after release both duplicates issue, qed_ready=1.
REQ-038 rst_n low asynchronously between clk edges in DUP with 3 buffered -> outputs at reset values before next edge; post-release ORIG, num_orig=0.

Source files
------------

// File: rtl/qed_dup_issue.sv
// QED duplicate-issue stage: passes originals to the core while buffering ALU ops,
// then replays each buffered op once with every register remapped to the upper bank.
module qed_dup_issue #(
    parameter int          DEPTH    = 8,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] NOP_INST = 32'h0000007F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ifu_inst,
    input  logic             ifu_valid,
    output logic             ifu_ready,
    input  logic             exec_dup,
    input  logic             stall,
    output logic [31:0]      qed_inst,
    output logic             qed_valid,
    output logic [CNT_W-1:0] num_orig,
    output logic [CNT_W-1:0] num_dup,
    output logic             qed_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_R = 7'b0110011;

    typedef enum logic [1:0] {ORIG, DUP, DONE} state_t;

    state_t          state, state_nxt;
    logic [31:0]     fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     fifo_cnt;
    logic            fifo_full, fifo_empty;
    logic            accept, push, pop;
    logic [31:0]     qi_nxt;
    logic            qv_nxt;

    // Duplicates use x16-x31 so they never alias the original's architectural state.
    function automatic logic [31:0] remap(input logic [31:0] inst);
        logic [31:0] r;
        r        = inst;
        r[11:7]  = inst[11:7]  | 5'b10000;
        r[19:15] = inst[19:15] | 5'b10000;
        if (inst[6:0] == OP_R)
            r[24:20] = inst[24:20] | 5'b10000;
        return r;
    endfunction

    assign fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign ifu_ready  = (state == ORIG) && !exec_dup && !stall && !fifo_full;
    assign accept     = ifu_valid && ifu_ready;
    assign qed_ready  = (state == DONE) && (num_orig == num_dup) && (num_orig != '0);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        qi_nxt    = qed_inst;
        qv_nxt    = qed_valid;
        if (!stall) begin
            qi_nxt = NOP_INST;
            qv_nxt = 1'b0;
            unique case (state)
                ORIG: begin
                    if (exec_dup) begin
                        state_nxt = DUP;
                    end else if (accept) begin
                        qi_nxt = ifu_inst;
                        qv_nxt = 1'b1;
                        push   = (ifu_inst[6:0] == OP_I) || (ifu_inst[6:0] == OP_R);
                    end
                end
                DUP: begin
                    if (fifo_empty) begin
                        state_nxt = DONE;
                    end else begin
                        pop    = 1'b1;
                        qi_nxt = remap(fifo_mem[rd_ptr]);
                        qv_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ORIG;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            num_orig  <= '0;
            num_dup   <= '0;
            qed_inst  <= NOP_INST;
            qed_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            qed_inst  <= qi_nxt;
            qed_valid <= qv_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (num_orig != {CNT_W{1'b1}})
                    num_orig <= num_orig + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (num_dup != {CNT_W{1'b1}})
                    num_dup <= num_dup + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= ifu_inst;
    end

endmodule

// File: tb/tb_qed_dup_issue.sv
// Scoreboard bench for qed_dup_issue: a reference model queues every expected
// valid issue; a negedge monitor pops and compares in order.
module tb_qed_dup_issue;

    localparam int          DEPTH = 8;
    localparam int          CNT_W = 8;
    localparam logic [31:0] NOP   = 32'h0000007F;
    localparam int M_ORIG = 0, M_DUP = 1, M_DONE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      ifu_inst;
    logic             ifu_valid, ifu_ready, exec_dup, stall;
    logic [31:0]      qed_inst;
    logic             qed_valid, qed_ready;
    logic [CNT_W-1:0] num_orig, num_dup;

    qed_dup_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .ifu_inst(ifu_inst), .ifu_valid(ifu_valid),
        .ifu_ready(ifu_ready), .exec_dup(exec_dup), .stall(stall),
        .qed_inst(qed_inst), .qed_valid(qed_valid), .num_orig(num_orig),
        .num_dup(num_dup), .qed_ready(qed_ready)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    int          m_state, m_orig, m_dup;
    logic [31:0] m_fifo[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_qi;
    logic        m_qv;
    logic        upd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dup_of(input logic [31:0] i);
        logic [31:0] m;
        m = 32'h0008_0800;
        if (i[6:0] == 7'h33) m = m | 32'h0100_0000;
        return i | m;
    endfunction

    // Monitor: only edges taken without stall and out of reset produce a new issue.
    always begin
        @(posedge clk);
        upd = rst_n && !stall;
        @(negedge clk);
        if (upd && rst_n) begin
            if (qed_valid) begin
                if (exp_q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
                else                   chk("issue_order", qed_inst, exp_q.pop_front());
            end else begin
                chk("idle_inst", qed_inst, NOP);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] inst, input logic d, input logic s);
        logic rdy, mrdy;
        ifu_valid = v; ifu_inst = inst; exec_dup = d; stall = s;
        #1;
        rdy = (m_state == M_ORIG) && !d && !s && (m_fifo.size() < DEPTH);
        chk("ifu_ready", {31'd0, ifu_ready}, {31'd0, rdy});
        @(posedge clk);
        if (!s) begin
            m_qi = NOP; m_qv = 1'b0;
            case (m_state)
                M_ORIG: begin
                    if (d) m_state = M_DUP;
                    else if (v && rdy) begin
                        m_qi = inst; m_qv = 1'b1;
                        exp_q.push_back(inst);
                        if (inst[6:0] == 7'h13 || inst[6:0] == 7'h33) begin
                            m_fifo.push_back(inst);
                            if (m_orig < 255) m_orig++;
                        end
                    end
                end
                M_DUP: begin
                    if (m_fifo.size() == 0) m_state = M_DONE;
                    else begin
                        m_qi = dup_of(m_fifo.pop_front()); m_qv = 1'b1;
                        exp_q.push_back(m_qi);
                        if (m_dup < 255) m_dup++;
                    end
                end
                default: ;
            endcase
        end
        #1;
        mrdy = (m_state == M_DONE) && (m_orig == m_dup) && (m_orig != 0);
        chk("num_orig", {24'd0, num_orig}, m_orig);
        chk("num_dup", {24'd0, num_dup}, m_dup);
        chk("qed_ready", {31'd0, qed_ready}, {31'd0, mrdy});
        chk("qed_inst_hold", qed_inst, m_qi);
        chk("qed_valid_hold", {31'd0, qed_valid}, {31'd0, m_qv});
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, s);
    endtask

    // Asserted between edges; outputs must reach reset values before the next edge.
    task automatic do_reset();
        rst_n = 1'b0; ifu_valid = 1'b0; exec_dup = 1'b0; stall = 1'b0;
        #1;
        chk("rst_valid", {31'd0, qed_valid}, 32'd0);
        chk("rst_inst", qed_inst, NOP);
        chk("rst_orig", {24'd0, num_orig}, 32'd0);
        chk("rst_dup", {24'd0, num_dup}, 32'd0);
        chk("rst_ready", {31'd0, qed_ready}, 32'd0);
        m_state = M_ORIG; m_fifo.delete(); exp_q.delete();
        m_orig = 0; m_dup = 0; m_qi = NOP; m_qv = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [31:0] mix [6];

    initial begin
        rst_n = 1'b0; ifu_valid = 1'b0; ifu_inst = '0; exec_dup = 1'b0; stall = 1'b0;
        mix[0] = 32'h00510093; mix[1] = 32'h002081B3; mix[2] = 32'h40118233;
        mix[3] = 32'h000010B7; mix[4] = 32'hFFF24293; mix[5] = 32'h02428333;
        @(posedge clk); #1;
        do_reset();

        // ADDI then duplicate
        step(1'b1, 32'h00510093, 1'b0, 1'b0);
        chk("t1_orig_inst", qed_inst, 32'h00510093);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("t1_dup_inst", qed_inst, 32'h00590893);
        idle(2, 1'b0);
        chk("t1_qed_ready", {31'd0, qed_ready}, 32'd1);

        // Mixed sequence with a non-ALU op, an accepted NOP and an ORIG stall
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, mix[i], 1'b0, 1'b0);
        step(1'b1, 32'h00308113, 1'b0, 1'b1);
        step(1'b1, NOP, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("t2_add_dup", qed_inst, 32'h012889B3);
        idle(6, 1'b0);

        // FIFO full: ninth offer refused
        do_reset();
        for (int k = 0; k < DEPTH + 1; k++) step(1'b1, 32'h00000093 | (k << 20), 1'b0, 1'b0);
        chk("t3_num_orig", {24'd0, num_orig}, 32'd8);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        idle(DEPTH + 2, 1'b0);
        chk("t3_num_dup", {24'd0, num_dup}, 32'd8);

        // NOP with exec_dup: nothing buffered, qed_ready stays low
        do_reset();
        step(1'b1, NOP, 1'b1, 1'b0);
        idle(3, 1'b0);

        // Stall inside DUP
        do_reset();
        step(1'b1, mix[0], 1'b0, 1'b0);
        step(1'b1, mix[1], 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        idle(3, 1'b1);
        chk("t5_dup_frozen", {24'd0, num_dup}, 32'd1);
        idle(3, 1'b0);
        chk("t5_qed_ready", {31'd0, qed_ready}, 32'd1);

        // Async reset mid-DUP with three buffered
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, mix[i], 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 32'h00510093, 1'b0, 1'b0);
        chk("t6_post_orig", {24'd0, num_orig}, 32'd1);
        idle(2, 1'b0);

        #10;
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
